cam_capture_ctrl: RTL and testbench
===================================

Name: cam_capture_ctrl

Overview:
- Frame-capture scheduler between cameraRead and the CNN input buffer.
- Arms on VSYNC and crops a CROP_W x CROP_H window out of the 320x240 RGB565 pixel stream.
- Writes the cropped pixels into one bank of a ping-pong frame buffer.
- Hands completed banks to the consumer through a ready/release handshake, and drops frames when both banks are full.

Parameters:
- SRC_W, 320, source line width (pixels).
- SRC_H, 240, source frame height (lines).
- CROP_X0, 48, first captured column.
- CROP_Y0, 8, first captured row.
- CROP_W, 224, captured width.
- CROP_H, 224, captured height.
- ADDR_W, 16, buffer word-address width; must satisfy 2^ADDR_W >= CROP_W*CROP_H.

Ports:
- i_clk  in  1  system clock; all inputs are synchronous to it.
- i_reset  in  1  synchronous, active-low reset.
- i_enable  in  1  continuous-capture enable (level).
- i_vsync  in  1  camera VSYNC, already synchronised to i_clk.
- i_pixelValid  in  1  one-cycle strobe per assembled pixel from cameraRead.
- i_pixel  in  16  RGB565 pixel.
- i_xIndex  in  10  pixel column.
- i_yIndex  in  10  pixel row.
- i_bufRelease  in  1  consumer finished with o_rdBank (one-cycle pulse).
- o_wrEn  out  1  buffer write strobe.
- o_wrAddr  out  ADDR_W  write address within bank.
- o_wrData  out  16  write data.
- o_wrBank  out  1  bank being written.
- o_frameReady  out  1  o_rdBank holds a complete frame.
- o_rdBank  out  1  bank the consumer must read.
- o_busy  out  1  state is CAPTURE.
- o_shortFrame  out  1  one-cycle pulse on an aborted (short) frame.
- o_dropCount  out  8  frames dropped because both banks were full; saturates at 255.

Behaviour:
- Reset (i_reset=0 at a clock edge):
  - All outputs 0, state IDLE, bankFull=2'b00, pixel counter 0.
  - The registered VSYNC copy is cleared to 0.
  - Reset mid-capture discards the partial frame and both banks.
- Frame start: rising edge of i_vsync, detected as i_vsync=1 while the previous-cycle copy is 0. One cycle of detection latency.
- States:
  - IDLE: go to WAIT_VSYNC when i_enable=1.
  - WAIT_VSYNC:
    - On frame start with a free bank: go to CAPTURE, set o_wrBank to the next write bank, clear the counter.
    - On frame start with both banks full: stay in WAIT_VSYNC and increment o_dropCount (saturating).
    - If i_enable=0: go to IDLE.
  - CAPTURE:
    - On i_pixelValid with CROP_X0<=x<CROP_X0+CROP_W and CROP_Y0<=y<CROP_Y0+CROP_H, register o_wrEn=1, o_wrData=i_pixel, o_wrAddr=counter, then increment the counter.
    - Write latency is exactly 1 cycle after i_pixelValid. o_wrEn is never high for two writes without matching strobes.
    - Out-of-window pixels produce no write.
    - When the write with address CROP_W*CROP_H-1 issues: next cycle set bankFull[o_wrBank], toggle the write-bank pointer, and go to WAIT_VSYNC (IDLE if i_enable=0).
    - i_enable deasserted mid-capture does not abort; the frame completes first.
  - Frame start during CAPTURE before completion (short frame):
    - Pulse o_shortFrame for 1 cycle; the bank is not marked full.
    - Clear the counter and restart capture into the same bank from this VSYNC.
- Bank handshake:
  - o_frameReady = bankFull[o_rdBank].
  - i_bufRelease while o_frameReady=1: clear bankFull[o_rdBank] and toggle o_rdBank.
  - i_bufRelease while o_frameReady=0: ignored.
  - Banks fill and release strictly alternately, so o_rdBank always points at the oldest full bank.
- Simultaneous events:
  - Completion and release in the same cycle: both apply (set one bit, clear the other).
  - Completion write and frame start in the same cycle: completion wins; the frame start is evaluated in WAIT_VSYNC rules on that edge.
  - Release freeing a bank in the same cycle as a frame start: the frame start still sees the bank as full and drops the frame.
- o_busy=1 exactly while state is CAPTURE.

Decomposition:
- Shared package cam_pkg:
  - state enum {IDLE, WAIT_VSYNC, CAPTURE}
  - SRC_W/SRC_H constants
  - RGB565 pixel typedef
  - FRAME_WORDS = CROP_W*CROP_H
- One sub-module, cam_bank_sched: owns the ping-pong logic (bankFull, write/read pointers, release handling, drop counter).
- The top holds the FSM, VSYNC edge detect, window compare and address counter.

Test Plan:
- Reset then i_enable=1, one full 320x240 frame -> exactly 50176 writes; first write data is pixel (48,8) at addr 0, last is pixel (271,231) at addr 50175; wrBank=0; o_frameReady=1 and o_rdBank=0 one cycle after the last write.
- Two frames with no release -> banks 0 and 1 full; third VSYNC -> no writes, o_dropCount=1; i_bufRelease -> o_rdBank=1, o_frameReady stays 1.
- VSYNC after 100 cropped rows -> o_shortFrame one-cycle pulse, o_frameReady=0; next complete frame is written from addr 0 into bank 0.
- Release on the exact cycle bank 1 completes while bank 0 is ready -> bankFull=2'b10, o_rdBank=1, o_frameReady=1.
- i_reset=0 for one cycle mid-capture (row 50) -> all outputs 0, bankFull=0; with i_enable=1, the next VSYNC captures into bank 0 from addr 0.
- i_enable dropped mid-frame -> frame completes, then state IDLE; a later VSYNC gives no writes and o_dropCount is unchanged.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera frame-capture scheduler.
package cam_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_VSYNC = 2'd1,
      CAPTURE    = 2'd2
   } cam_state_e;

   typedef logic [15:0] rgb565_t;

   localparam int SRC_W = 320;
   localparam int SRC_H = 240;

   function automatic int frame_words(input int w, input int h);
      return w * h;
   endfunction

   // Window end clipped to the source raster so a misplaced crop never wraps.
   function automatic int win_end(input int lo, input int len, input int lim);
      return ((lo + len) > lim) ? lim : (lo + len);
   endfunction

endpackage

// File: rtl/cam_capture_ctrl_if.sv
// Pixel stream, buffer write port and bank handshake of the capture scheduler.
interface cam_capture_ctrl_if #(
   parameter int ADDR_W = 16
) ();
   import cam_pkg::*;

   logic              i_enable;
   logic              i_vsync;
   logic              i_pixelValid;
   rgb565_t           i_pixel;
   logic [9:0]        i_xIndex;
   logic [9:0]        i_yIndex;
   logic              i_bufRelease;
   logic              o_wrEn;
   logic [ADDR_W-1:0] o_wrAddr;
   rgb565_t           o_wrData;
   logic              o_wrBank;
   logic              o_frameReady;
   logic              o_rdBank;
   logic              o_busy;
   logic              o_shortFrame;
   logic [7:0]        o_dropCount;

   modport master (
      output i_enable, i_vsync, i_pixelValid, i_pixel, i_xIndex, i_yIndex, i_bufRelease,
      input  o_wrEn, o_wrAddr, o_wrData, o_wrBank, o_frameReady, o_rdBank,
             o_busy, o_shortFrame, o_dropCount
   );

   modport slave (
      input  i_enable, i_vsync, i_pixelValid, i_pixel, i_xIndex, i_yIndex, i_bufRelease,
      output o_wrEn, o_wrAddr, o_wrData, o_wrBank, o_frameReady, o_rdBank,
             o_busy, o_shortFrame, o_dropCount
   );

endinterface

// File: rtl/cam_bank_sched.sv
// Ping-pong bank bookkeeping: full flags, write/read pointers, release and drop count.
module cam_bank_sched (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       complete,
   input  logic       buf_release,
   input  logic       drop,
   output logic [1:0] bank_full_r,
   output logic       wr_ptr_r,
   output logic       rd_ptr_r,
   output logic       frame_ready_r,
   output logic [7:0] drop_count_r
);

   logic [1:0] bank_full_nxt;
   logic       wr_ptr_nxt;
   logic       rd_ptr_nxt;
   logic [7:0] drop_count_nxt;

   // Completion and release touch different banks, so both may apply together.
   always_comb begin
      bank_full_nxt  = bank_full_r;
      wr_ptr_nxt     = wr_ptr_r;
      rd_ptr_nxt     = rd_ptr_r;
      drop_count_nxt = drop_count_r;
      if (complete) begin
         bank_full_nxt[wr_ptr_r] = 1'b1;
         wr_ptr_nxt              = ~wr_ptr_r;
      end else begin
         wr_ptr_nxt = wr_ptr_r;
      end
      if (buf_release && bank_full_r[rd_ptr_r]) begin
         bank_full_nxt[rd_ptr_r] = 1'b0;
         rd_ptr_nxt              = ~rd_ptr_r;
      end else begin
         rd_ptr_nxt = rd_ptr_r;
      end
      if (drop && (drop_count_r != 8'hFF)) begin
         drop_count_nxt = drop_count_r + 8'd1;
      end else begin
         drop_count_nxt = drop_count_r;
      end
   end

   // Bank state registers.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         bank_full_r   <= 2'b00;
         wr_ptr_r      <= 1'b0;
         rd_ptr_r      <= 1'b0;
         frame_ready_r <= 1'b0;
         drop_count_r  <= 8'd0;
      end else begin
         bank_full_r   <= bank_full_nxt;
         wr_ptr_r      <= wr_ptr_nxt;
         rd_ptr_r      <= rd_ptr_nxt;
         frame_ready_r <= bank_full_nxt[rd_ptr_nxt];
         drop_count_r  <= drop_count_nxt;
      end
   end

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame-capture scheduler: VSYNC-armed crop of the camera raster into a ping-pong buffer.
module cam_capture_ctrl #(
   parameter int SRC_W   = cam_pkg::SRC_W,
   parameter int SRC_H   = cam_pkg::SRC_H,
   parameter int CROP_X0 = 48,
   parameter int CROP_Y0 = 8,
   parameter int CROP_W  = 224,
   parameter int CROP_H  = 224,
   parameter int ADDR_W  = 16
) (
   input  logic          i_clk,
   input  logic          i_reset,
   cam_capture_ctrl_if.slave bus
);
   import cam_pkg::*;

   localparam logic [9:0]        X_LO      = 10'(CROP_X0);
   localparam logic [9:0]        X_HI      = 10'(win_end(CROP_X0, CROP_W, SRC_W));
   localparam logic [9:0]        Y_LO      = 10'(CROP_Y0);
   localparam logic [9:0]        Y_HI      = 10'(win_end(CROP_Y0, CROP_H, SRC_H));
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(frame_words(CROP_W, CROP_H) - 1);

   cam_state_e        state_r, state_nxt;
   logic              vsync_r;
   logic [ADDR_W-1:0] count_r, count_nxt;
   logic              wr_en_r, wr_en_nxt;
   logic [ADDR_W-1:0] wr_addr_r, wr_addr_nxt;
   rgb565_t           wr_data_r, wr_data_nxt;
   logic              wr_bank_r, wr_bank_nxt;
   logic              done_pend_r, done_pend_nxt;
   logic              short_r, short_nxt;
   logic              busy_r;
   logic              frame_start_s, in_win_s, complete_s, drop_s;
   logic [1:0]        bank_full_s;
   logic              wr_ptr_s, rd_ptr_s, frame_ready_s;
   logic [7:0]        drop_count_s;

   assign frame_start_s = bus.i_vsync & ~vsync_r;
   assign in_win_s      = (bus.i_xIndex >= X_LO) && (bus.i_xIndex < X_HI) &&
                          (bus.i_yIndex >= Y_LO) && (bus.i_yIndex < Y_HI);

   // Next state; done_pend_r marks the cycle after the final write, when the bank is closed.
   always_comb begin
      state_nxt     = state_r;
      count_nxt     = count_r;
      wr_en_nxt     = 1'b0;
      wr_addr_nxt   = wr_addr_r;
      wr_data_nxt   = wr_data_r;
      wr_bank_nxt   = wr_bank_r;
      done_pend_nxt = 1'b0;
      short_nxt     = 1'b0;
      complete_s    = 1'b0;
      drop_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.i_enable) state_nxt = WAIT_VSYNC;
            else              state_nxt = IDLE;
         end
         WAIT_VSYNC: begin
            if (!bus.i_enable) begin
               state_nxt = IDLE;
            end else if (frame_start_s && !bank_full_s[wr_ptr_s]) begin
               state_nxt   = CAPTURE;
               wr_bank_nxt = wr_ptr_s;
               count_nxt   = {ADDR_W{1'b0}};
            end else if (frame_start_s) begin
               drop_s = 1'b1;
            end else begin
               state_nxt = WAIT_VSYNC;
            end
         end
         CAPTURE: begin
            if (done_pend_r) begin
               complete_s = 1'b1;
               if (!bus.i_enable) begin
                  state_nxt = IDLE;
               end else if (frame_start_s && !bank_full_s[~wr_ptr_s]) begin
                  state_nxt   = CAPTURE;
                  wr_bank_nxt = ~wr_ptr_s;
                  count_nxt   = {ADDR_W{1'b0}};
               end else if (frame_start_s) begin
                  drop_s    = 1'b1;
                  state_nxt = WAIT_VSYNC;
               end else begin
                  state_nxt = WAIT_VSYNC;
               end
            end else if (frame_start_s) begin
               short_nxt = 1'b1;
               count_nxt = {ADDR_W{1'b0}};
            end else if (bus.i_pixelValid && in_win_s) begin
               wr_en_nxt     = 1'b1;
               wr_addr_nxt   = count_r;
               wr_data_nxt   = bus.i_pixel;
               count_nxt     = count_r + {{(ADDR_W-1){1'b0}}, 1'b1};
               done_pend_nxt = (count_r == LAST_ADDR);
            end else begin
               state_nxt = CAPTURE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM, VSYNC history and registered write-port outputs.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_r     <= IDLE;
         vsync_r     <= 1'b0;
         count_r     <= {ADDR_W{1'b0}};
         wr_en_r     <= 1'b0;
         wr_addr_r   <= {ADDR_W{1'b0}};
         wr_data_r   <= 16'h0000;
         wr_bank_r   <= 1'b0;
         done_pend_r <= 1'b0;
         short_r     <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt;
         vsync_r     <= bus.i_vsync;
         count_r     <= count_nxt;
         wr_en_r     <= wr_en_nxt;
         wr_addr_r   <= wr_addr_nxt;
         wr_data_r   <= wr_data_nxt;
         wr_bank_r   <= wr_bank_nxt;
         done_pend_r <= done_pend_nxt;
         short_r     <= short_nxt;
         busy_r      <= (state_nxt == CAPTURE);
      end
   end

   cam_bank_sched u_bank_sched (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .complete      (complete_s),
      .buf_release   (bus.i_bufRelease),
      .drop          (drop_s),
      .bank_full_r   (bank_full_s),
      .wr_ptr_r      (wr_ptr_s),
      .rd_ptr_r      (rd_ptr_s),
      .frame_ready_r (frame_ready_s),
      .drop_count_r  (drop_count_s)
   );

   assign bus.o_wrEn       = wr_en_r;
   assign bus.o_wrAddr     = wr_addr_r;
   assign bus.o_wrData     = wr_data_r;
   assign bus.o_wrBank     = wr_bank_r;
   assign bus.o_frameReady = frame_ready_s;
   assign bus.o_rdBank     = rd_ptr_s;
   assign bus.o_busy       = busy_r;
   assign bus.o_shortFrame = short_r;
   assign bus.o_dropCount  = drop_count_s;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench: one full-size frame on a default instance, then a small-crop instance driven by random frames against a frame-level model.
module tb_cam_capture_ctrl;

   localparam int SW = 12, SH = 10, X0 = 3, Y0 = 2, W = 6, H = 5, FW = W * H;
   localparam int M_IDLE = 0, M_WAIT = 1, M_CAP = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cam_capture_ctrl_if #(.ADDR_W(16)) fb ();
   cam_capture_ctrl_if #(.ADDR_W(5))  sb ();

   cam_capture_ctrl u_full (.i_clk(clk), .i_reset(rst_n), .bus(fb));
   cam_capture_ctrl #(.CROP_X0(X0), .CROP_Y0(Y0), .CROP_W(W), .CROP_H(H), .ADDR_W(5))
      u_small (.i_clk(clk), .i_reset(rst_n), .bus(sb));

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] full_pix(input int x, input int y);
      return 16'(x * 241 + y * 7);
   endfunction

   // Full-size instance observation: every write must be the next raster pixel of the window.
   int          full_n = 0, full_err = 0;
   logic [15:0] full_first, full_last;
   logic        full_next = 1'b0, full_rdy_at, full_rdy_after, full_rd_after;
   always @(negedge clk) begin
      if (full_next) begin
         full_rdy_after = fb.o_frameReady;
         full_rd_after  = fb.o_rdBank;
         full_next      = 1'b0;
      end
      if (fb.o_wrEn) begin
         if (fb.o_wrAddr !== 16'(full_n) || fb.o_wrBank !== 1'b0 ||
             fb.o_wrData !== full_pix(48 + full_n % 224, 8 + full_n / 224)) full_err++;
         if (full_n == 0) full_first = fb.o_wrData;
         if (full_n == 50175) begin
            full_last   = fb.o_wrData;
            full_rdy_at = fb.o_frameReady;
            full_next   = 1'b1;
         end
         full_n++;
      end
   end

   // Frame-level reference model for the small instance.
   int          m_state = M_IDLE, m_count = 0, m_rd = 0, m_wr = 0, m_bank = 0;
   int          m_drop = 0, m_short = 0;
   bit          m_full[2] = '{1'b0, 1'b0};
   bit          m_en = 1'b0;
   logic [31:0] exp_q[$];
   int          short_seen = 0;

   always @(negedge clk) begin
      if (sb.o_shortFrame) short_seen++;
      if (sb.o_wrEn) begin
         if (exp_q.size() == 0) begin
            check_val("sm_wr_unexpected", {31'd0, sb.o_wrEn}, 32'd0);
         end else begin
            check_val("sm_wr", {10'd0, sb.o_wrBank, sb.o_wrAddr, sb.o_wrData}, exp_q.pop_front());
         end
      end
   end

   task automatic model_vsync();
      if (m_state == M_CAP) begin
         m_short++;
         m_count = 0;
      end else if (m_state == M_WAIT) begin
         if (!m_full[m_wr]) begin
            m_state = M_CAP;
            m_bank  = m_wr;
            m_count = 0;
         end else if (m_drop < 255) begin
            m_drop++;
         end
      end
   endtask

   task automatic model_pixel(input int x, input int y, input logic [15:0] d);
      if (m_state == M_CAP && x >= X0 && x < X0 + W && y >= Y0 && y < Y0 + H) begin
         exp_q.push_back({10'd0, 1'(m_bank), 5'(m_count), d});
         m_count++;
         if (m_count == FW) begin
            m_full[m_bank] = 1'b1;
            m_wr           = 1 - m_wr;
            m_state        = m_en ? M_WAIT : M_IDLE;
         end
      end
   endtask

   task automatic model_release();
      if (m_full[m_rd]) begin
         m_full[m_rd] = 1'b0;
         m_rd         = 1 - m_rd;
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sm_enable(input bit v);
      sb.i_enable = v;
      m_en        = v;
      if (m_state == M_IDLE && v) m_state = M_WAIT;
      else if (m_state == M_WAIT && !v) m_state = M_IDLE;
      cyc(2);
   endtask

   task automatic sm_release();
      sb.i_bufRelease = 1'b1;
      model_release();
      cyc(1);
      sb.i_bufRelease = 1'b0;
      cyc(2);
   endtask

   // Release (when asked) lands on the cycle right after the pixel strobe.
   task automatic sm_pixel(input int x, input int y, input bit rel);
      logic [15:0] d;
      d               = 16'($urandom);
      sb.i_pixelValid = 1'b1;
      sb.i_pixel      = d;
      sb.i_xIndex     = 10'(x);
      sb.i_yIndex     = 10'(y);
      if (rel) model_release();
      model_pixel(x, y, d);
      cyc(1);
      sb.i_pixelValid = 1'b0;
      if (rel) begin
         sb.i_bufRelease = 1'b1;
         cyc(1);
         sb.i_bufRelease = 1'b0;
      end
      cyc($urandom_range(0, 2));
   endtask

   task automatic sm_frame(input int rows, input bit rel_end, input int en_off_row);
      sb.i_vsync = 1'b1;
      model_vsync();
      cyc(2);
      sb.i_vsync = 1'b0;
      cyc(1);
      for (int y = 0; y < rows; y++) begin
         for (int x = 0; x < SW; x++) begin
            if (y == en_off_row && x == 0) sm_enable(1'b0);
            sm_pixel(x, y, rel_end && x == X0 + W - 1 && y == Y0 + H - 1);
         end
      end
      cyc(4);
   endtask

   task automatic sm_status(input string tag);
      @(negedge clk);
      check_val({tag, "_rdy"},   {31'd0, sb.o_frameReady}, {31'd0, m_full[m_rd]});
      check_val({tag, "_rd"},    {31'd0, sb.o_rdBank},     32'(m_rd));
      check_val({tag, "_drop"},  {24'd0, sb.o_dropCount},  32'(m_drop));
      check_val({tag, "_busy"},  {31'd0, sb.o_busy},       {31'd0, m_state == M_CAP});
      check_val({tag, "_short"}, 32'(short_seen),          32'(m_short));
      @(posedge clk);
      #1;
   endtask

   task automatic sm_reset();
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("rst_wr", {9'd0, sb.o_wrEn, sb.o_wrAddr, sb.o_wrData, sb.o_wrBank}, 32'd0);
      check_val("rst_ctl", {20'd0, sb.o_frameReady, sb.o_rdBank, sb.o_busy, sb.o_shortFrame,
                            sb.o_dropCount}, 32'd0);
      m_state = M_IDLE; m_count = 0; m_rd = 0; m_wr = 0; m_bank = 0; m_drop = 0;
      m_full[0] = 1'b0;
      m_full[1] = 1'b0;
      @(posedge clk);
      #1;
      cyc(2);
      m_state = m_en ? M_WAIT : M_IDLE;
   endtask

   initial begin
      {fb.i_enable, fb.i_vsync, fb.i_pixelValid, fb.i_bufRelease} = 4'b0000;
      {sb.i_enable, sb.i_vsync, sb.i_pixelValid, sb.i_bufRelease} = 4'b0000;
      fb.i_pixel = 16'h0000; fb.i_xIndex = 10'd0; fb.i_yIndex = 10'd0;
      sb.i_pixel = 16'h0000; sb.i_xIndex = 10'd0; sb.i_yIndex = 10'd0;
      cyc(3);
      @(negedge clk);
      check_val("init_full", {fb.o_wrEn, fb.o_frameReady, fb.o_rdBank, fb.o_busy, fb.o_dropCount,
                              fb.o_wrAddr}, 32'd0);
      check_val("init_small", {sb.o_wrEn, sb.o_frameReady, sb.o_rdBank, sb.o_busy, sb.o_dropCount,
                               sb.o_wrData}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Full-size raster with a one-pixel margin around the 224x224 window.
      fb.i_enable = 1'b1;
      cyc(2);
      fb.i_vsync = 1'b1;
      cyc(2);
      fb.i_vsync = 1'b0;
      for (int y = 7; y <= 232; y++) begin
         for (int x = 47; x <= 272; x++) begin
            fb.i_pixelValid = 1'b1;
            fb.i_pixel      = full_pix(x, y);
            fb.i_xIndex     = 10'(x);
            fb.i_yIndex     = 10'(y);
            cyc(1);
         end
      end
      fb.i_pixelValid = 1'b0;
      cyc(6);
      check_val("full_count", 32'(full_n), 32'd50176);
      check_val("full_seq_err", 32'(full_err), 32'd0);
      check_val("full_first", {16'd0, full_first}, {16'd0, full_pix(48, 8)});
      check_val("full_last", {16'd0, full_last}, {16'd0, full_pix(271, 231)});
      check_val("full_rdy_at_last", {31'd0, full_rdy_at}, 32'd0);
      check_val("full_rdy_after", {31'd0, full_rdy_after}, 32'd1);
      check_val("full_rd_after", {31'd0, full_rd_after}, 32'd0);

      // Small instance: fill both banks, drop, release, short frame, simultaneous release.
      sm_enable(1'b1);
      sm_frame(SH, 1'b0, -1);     sm_status("f1");
      sm_frame(SH, 1'b0, -1);     sm_status("f2");
      sm_frame(SH, 1'b0, -1);     sm_status("f3_drop");
      sm_release();               sm_status("rel1");
      sm_release();               sm_status("rel2");
      sm_frame(Y0 + 3, 1'b0, -1); sm_status("part");
      sm_frame(SH, 1'b0, -1);     sm_status("short_full");
      sm_frame(SH, 1'b1, -1);     sm_status("sim");
      check_val("sim_full_vec", {30'd0, u_small.bank_full_s}, 32'b10);
      sm_release();               sm_status("sim_rel");

      for (int i = 0; i < 16; i++) begin
         case ($urandom_range(0, 5))
            0, 1:    sm_frame(SH, 1'b0, -1);
            2:       sm_frame(Y0 + 1 + $urandom_range(0, 2), 1'b0, -1);
            3:       sm_release();
            4:       sm_enable(!m_en);
            default: sm_frame(SH, 1'b1, -1);
         endcase
         sm_status("rnd");
      end

      // Reset in the middle of a capture, then recapture from bank 0.
      if (!m_en) sm_enable(1'b1);
      sm_release();
      sm_release();
      sm_frame(Y0 + 3, 1'b0, -1);
      sm_reset();                 sm_status("post_rst");
      sm_frame(SH, 1'b0, -1);     sm_status("rst_frame");

      // Enable dropped mid-frame: frame finishes, later VSYNC is ignored.
      sm_frame(SH, 1'b0, Y0 + 2); sm_status("en_off");
      sm_frame(SH, 1'b0, -1);     sm_status("en_off_vsync");

      cyc(4);
      check_val("sm_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
